// File: rtl/vq_decompress_engine.sv
// vq_decompress_engine: loads a VQ codebook from RAM1, then expands packed RAM2 tags into RAM3 pixels.
// Decode pipeline: tag fetch -> tag select -> codebook lookup/registered write, one pixel per cycle.
module vq_decompress_engine #(
    parameter int DATA_W        = 24,
    parameter int ADDR_W        = 20,
    parameter int CB_DEPTH      = 64,
    parameter int TAGS_PER_WORD = 1,
    localparam int IDX_W        = $clog2(CB_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [IDX_W:0]    cb_len,
    input  logic [ADDR_W-1:0] num_pix,
    input  logic [DATA_W-1:0] RAM1_Q,
    output logic [ADDR_W-1:0] RAM1_A,
    output logic              RAM1_OE,
    output logic [DATA_W-1:0] RAM1_D,
    output logic              RAM1_WE,
    input  logic [DATA_W-1:0] RAM2_Q,
    output logic [ADDR_W-1:0] RAM2_A,
    output logic              RAM2_OE,
    output logic [DATA_W-1:0] RAM2_D,
    output logic              RAM2_WE,
    output logic [DATA_W-1:0] RAM3_D,
    output logic [ADDR_W-1:0] RAM3_A,
    output logic              RAM3_WE,
    output logic              RAM3_OE,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam int J_W = TAGS_PER_WORD > 1 ? $clog2(TAGS_PER_WORD) : 1;
    localparam logic [IDX_W:0] CB_FULL = (IDX_W+1)'(CB_DEPTH);
    typedef enum logic [2:0] {IDLE, LOAD_CB, DECODE, DRAIN, FINISH} state_t;
    state_t state, state_n;
    logic [IDX_W:0]    len, ld;
    logic [ADDR_W-1:0] npix, pix, word;
    logic [J_W-1:0]    j, s1_j;
    logic [1:0]        dcnt;
    logic              rd_v, s1_v, s1_new, s2_v, last_j, bad;
    logic [IDX_W-1:0]  rd_idx, s2_tag;
    logic [ADDR_W-1:0] s1_k, s2_k;
    logic [DATA_W-1:0] word_q, cur_word;
    logic [IDX_W-1:0]  tags [TAGS_PER_WORD];
    logic [DATA_W-1:0] cb [CB_DEPTH];
    logic              unused_word_bits;
    assign RAM1_D  = '0;
    assign RAM1_WE = 1'b0;
    assign RAM2_D  = '0;
    assign RAM2_WE = 1'b0;
    assign RAM3_OE = 1'b0;
    assign busy    = state != IDLE;
    assign done    = state == FINISH;
    assign RAM1_OE = state == LOAD_CB && ld < len;
    assign RAM1_A  = RAM1_OE ? ADDR_W'(ld) : '0;
    assign RAM2_OE = state == DECODE && j == '0;
    assign RAM2_A  = RAM2_OE ? word : '0;
    assign last_j  = j == J_W'(TAGS_PER_WORD - 1);
    // RAM2 output is only trusted the cycle after a read, so later tags of a word come from word_q
    assign cur_word = s1_new ? RAM2_Q : word_q;
    assign unused_word_bits = ^cur_word;
    assign bad = {1'b0, s2_tag} >= len;
    for (genvar g = 0; g < TAGS_PER_WORD; g++) begin : g_tag
        assign tags[g] = cur_word[g*IDX_W +: IDX_W];
    end
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = start ? LOAD_CB : IDLE;
            LOAD_CB: if (ld == len) state_n = npix == '0 ? DRAIN : DECODE;
            DECODE:  if (pix == npix - ADDR_W'(1)) state_n = DRAIN;
            DRAIN:   if (dcnt == 2'd2) state_n = FINISH;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rd_v) cb[rd_idx] <= RAM1_Q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            len     <= '0;
            npix    <= '0;
            ld      <= '0;
            pix     <= '0;
            word    <= '0;
            j       <= '0;
            dcnt    <= '0;
            rd_v    <= 1'b0;
            rd_idx  <= '0;
            s1_v    <= 1'b0;
            s1_new  <= 1'b0;
            s1_j    <= '0;
            s1_k    <= '0;
            s2_v    <= 1'b0;
            s2_tag  <= '0;
            s2_k    <= '0;
            word_q  <= '0;
            RAM3_WE <= 1'b0;
            RAM3_A  <= '0;
            RAM3_D  <= '0;
            err     <= 1'b0;
        end else begin
            state <= state_n;
            if (state == IDLE && start) begin
                len  <= cb_len == '0 ? CB_FULL : cb_len;
                npix <= num_pix;
                ld   <= '0;
                pix  <= '0;
                word <= '0;
                j    <= '0;
                dcnt <= '0;
            end
            if (RAM1_OE) ld <= ld + (IDX_W+1)'(1);
            rd_v   <= RAM1_OE;
            rd_idx <= ld[IDX_W-1:0];
            if (state == DECODE) begin
                pix <= pix + ADDR_W'(1);
                j   <= last_j ? '0 : j + J_W'(1);
                if (last_j) word <= word + ADDR_W'(1);
            end
            if (state == DRAIN) dcnt <= dcnt + 2'd1;
            s1_v   <= state == DECODE;
            s1_new <= RAM2_OE;
            s1_j   <= j;
            s1_k   <= pix;
            if (s1_v) word_q <= cur_word;
            s2_v    <= s1_v;
            s2_tag  <= tags[s1_j];
            s2_k    <= s1_k;
            RAM3_WE <= s2_v;
            RAM3_A  <= s2_v ? s2_k : '0;
            RAM3_D  <= s2_v && !bad ? cb[s2_tag] : '0;
            err     <= (state == IDLE && start) ? 1'b0 : err | (s2_v && bad);
        end
    end
endmodule

// File: tb/tb_vq_decompress_engine.sv
// tb_vq_decompress_engine: directed jobs with a write scoreboard checked by a negedge monitor.
module tb_vq_decompress_engine;
    localparam int DATA_W = 24, ADDR_W = 20, CB_DEPTH = 64, TPW = 4, IDX_W = 6;
    logic clk, rst, start;
    logic [IDX_W:0] cb_len;
    logic [ADDR_W-1:0] num_pix;
    logic [DATA_W-1:0] RAM1_Q, RAM1_D, RAM2_Q, RAM2_D, RAM3_D;
    logic [ADDR_W-1:0] RAM1_A, RAM2_A, RAM3_A;
    logic RAM1_OE, RAM1_WE, RAM2_OE, RAM2_WE, RAM3_WE, RAM3_OE, busy, done, err;
    logic [DATA_W-1:0] mem1 [64];
    logic [DATA_W-1:0] mem2 [64];
    logic [43:0] sb [$];
    int tags [$];
    int checks = 0, fails = 0, rd1 = 0, rd2 = 0, wr = 0;

    vq_decompress_engine #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CB_DEPTH(CB_DEPTH), .TAGS_PER_WORD(TPW)) dut (
        .clk(clk), .rst(rst), .start(start), .cb_len(cb_len), .num_pix(num_pix),
        .RAM1_Q(RAM1_Q), .RAM1_A(RAM1_A), .RAM1_OE(RAM1_OE), .RAM1_D(RAM1_D), .RAM1_WE(RAM1_WE),
        .RAM2_Q(RAM2_Q), .RAM2_A(RAM2_A), .RAM2_OE(RAM2_OE), .RAM2_D(RAM2_D), .RAM2_WE(RAM2_WE),
        .RAM3_D(RAM3_D), .RAM3_A(RAM3_A), .RAM3_WE(RAM3_WE), .RAM3_OE(RAM3_OE),
        .busy(busy), .done(done), .err(err));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read data is scrambled on idle cycles so stale-output reliance shows up
    always @(posedge clk) begin
        RAM1_Q <= RAM1_OE ? mem1[RAM1_A[5:0]] : DATA_W'($urandom);
        RAM2_Q <= RAM2_OE ? mem2[RAM2_A[5:0]] : DATA_W'($urandom);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (RAM1_OE) rd1++;
        if (RAM2_OE) rd2++;
        if (RAM3_WE) begin
            wr++;
            if (sb.size() == 0) chk("unexpected_write", {RAM3_A, RAM3_D}, 64'hdead);
            else chk($sformatf("pixel_%0d", RAM3_A), {RAM3_A, RAM3_D}, sb.pop_front());
        end
    end

    task automatic load_tags();
        for (int w = 0; w < 64; w++) mem2[w] = '0;
        for (int k = 0; k < tags.size(); k++) mem2[k/TPW][(k%TPW)*IDX_W +: IDX_W] = IDX_W'(tags[k]);
    endtask

    task automatic push_expected(input int cl, input int np);
        int l;
        l = cl == 0 ? 64 : cl;
        for (int k = 0; k < np; k++)
            sb.push_back({ADDR_W'(k), tags[k] < l ? mem1[tags[k]] : 24'h0});
    endtask

    task automatic run_job(input string name, input int cl, input int np, input int exp_lat,
                           input int exp_rd2, input bit exp_err, input int poke);
        int lat;
        load_tags();
        push_expected(cl, np);
        rd1 = 0; rd2 = 0; wr = 0;
        @(negedge clk);
        cb_len = (IDX_W+1)'(cl); num_pix = ADDR_W'(np); start = 1'b1;
        @(negedge clk);
        start = 1'b0; lat = 0;
        chk({name, "_err_clear"}, err, 0);
        chk({name, "_busy"}, busy, 1);
        while (!done && lat < 3000) begin
            @(negedge clk);
            lat++;
            start = lat == poke;
            if (lat == poke) begin cb_len = 7'd1; num_pix = 20'd2; end
        end
        start = 1'b0;
        chk({name, "_latency"}, lat, exp_lat);
        chk({name, "_err"}, err, exp_err);
        chk({name, "_ram1_reads"}, rd1, cl == 0 ? 64 : cl);
        chk({name, "_ram2_reads"}, rd2, exp_rd2);
        @(negedge clk);
        chk({name, "_done_pulse"}, {busy, done}, 0);
        chk({name, "_writes"}, wr, np);
        chk({name, "_sb_empty"}, sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; cb_len = '0; num_pix = '0;
        for (int i = 0; i < 64; i++) mem1[i] = DATA_W'(24'h111111 * (i + 1));
        repeat (3) @(negedge clk);
        chk("reset_ctrl", {busy, done, err}, 0);
        chk("reset_oe_we", {RAM1_OE, RAM2_OE, RAM3_WE}, 0);
        chk("reset_addr_data", {RAM1_A, RAM2_A, RAM3_A, RAM3_D}, 0);
        chk("tied_outputs", {RAM1_D, RAM2_D, RAM1_WE, RAM2_WE, RAM3_OE}, 0);
        rst = 1'b0;
        tags = '{0, 1, 2, 3, 3, 2, 1, 0};
        run_job("basic", 4, 8, 16, 2, 0, -1);
        tags = '{7, 63, 0, 12, 40, 33, 5, 62, 1, 2, 50, 60};
        run_job("full_cb", 0, 10, 78, 3, 0, -1);
        tags = '{0, 5, 2, 3};
        run_job("bad_tag", 4, 4, 12, 1, 1, -1);
        tags = '{};
        run_job("zero_pix", 2, 0, 6, 0, 0, -1);
        tags = '{2, 1, 0, 2, 1};
        run_job("busy_start", 3, 5, 12, 2, 0, 3);
        // Abort mid-decode right after the third pixel is written
        tags = '{0, 1, 2, 3, 3, 2, 1, 0};
        load_tags();
        push_expected(4, 8);
        wr = 0;
        @(negedge clk);
        cb_len = 7'd4; num_pix = 20'd8; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        sb.delete();
        chk("abort_writes", wr, 3);
        chk("abort_ctrl", {busy, done, err, RAM1_OE, RAM2_OE, RAM3_WE}, 0);
        chk("abort_addr_data", {RAM3_A, RAM3_D, RAM2_A}, 0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("abort_quiet", wr, 3);
        run_job("after_abort", 4, 8, 16, 2, 0, -1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
